// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: checks a one-hot ring counter for legal codes and rotation, tracks lock, revolutions and errors
module ring_phase_monitor #(
  parameter int WIDTH = 4,
  parameter bit DIR = 1'b0,
  parameter int LOCK_CNT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         q_in,
  input  logic [WIDTH-1:0]         qb_in,
  input  logic                     clr_err,
  output logic                     locked,
  output logic                     err,
  output logic                     err_sticky,
  output logic [7:0]               err_cnt,
  output logic [15:0]              rev_cnt,
  output logic                     rev_pulse,
  output logic [$clog2(WIDTH)-1:0] phase,
  output logic [1:0]               state
);
  localparam int PW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED, FAULT} state_t;
  state_t st, st_n;
  logic [WIDTH-1:0] q1, qb1, prev, rot;
  logic en1, valid, correct, err_n, rev_n;
  logic [3:0] good_cnt, good_n;
  logic [PW-1:0] idx;
  assign valid = $onehot(q1) && (qb1 == ~q1);
  assign rot = DIR ? {prev[0], prev[WIDTH-1:1]} : {prev[WIDTH-2:0], prev[WIDTH-1]};
  assign correct = valid && (q1 == rot);
  assign locked = st == LOCKED;
  assign state = st;
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (q1[i]) idx = i[PW-1:0];
  end
  always_comb begin
    st_n = st;
    good_n = good_cnt;
    err_n = 1'b0;
    rev_n = 1'b0;
    if (en1)
      case (st)
        IDLE, FAULT: begin
          st_n = valid ? SEARCH : st;
          good_n = valid ? 4'd0 : good_cnt;
        end
        SEARCH: begin
          st_n = correct ? ((good_cnt + 4'd1 == 4'(LOCK_CNT)) ? LOCKED : SEARCH) : (valid ? SEARCH : IDLE);
          good_n = (correct && (good_cnt + 4'd1 != 4'(LOCK_CNT))) ? good_cnt + 4'd1 : 4'd0;
        end
        default: begin
          st_n = correct ? LOCKED : FAULT;
          err_n = !correct;
          rev_n = correct && q1[0];
        end
      endcase
  end
  // stage 1 captures the raw inputs; stage 2 evaluates them against the stored previous sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= '0;
      qb1 <= '0;
      en1 <= 1'b0;
      prev <= '0;
      st <= IDLE;
      good_cnt <= 4'd0;
      phase <= '0;
      err <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt <= 8'd0;
      rev_pulse <= 1'b0;
      rev_cnt <= 16'd0;
    end else begin
      q1 <= q_in;
      qb1 <= qb_in;
      en1 <= en;
      st <= st_n;
      good_cnt <= good_n;
      err <= err_n;
      rev_pulse <= rev_n;
      if (en1 && valid) begin
        prev <= q1;
        phase <= idx;
      end
      if (rev_n) rev_cnt <= rev_cnt + 16'd1;
      err_sticky <= err_n ? 1'b1 : (clr_err ? 1'b0 : err_sticky);
      err_cnt <= err_n ? (clr_err ? 8'd1 : (err_cnt == 8'hFF ? err_cnt : err_cnt + 8'd1))
                       : (clr_err ? 8'd0 : err_cnt);
    end
  end
endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor: directed checks of lock, revolutions, faults, gating, saturation, clear and reset
module tb_ring_phase_monitor;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, clr_err = 1'b0;
  logic [3:0] q_in = 4'd0, qb_in = 4'd0;
  logic locked, err, err_sticky, rev_pulse;
  logic [7:0] err_cnt;
  logic [15:0] rev_cnt;
  logic [1:0] phase, state;
  int checks = 0, errors = 0;
  ring_phase_monitor #(.WIDTH(4), .DIR(1'b0), .LOCK_CNT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .q_in(q_in), .qb_in(qb_in), .clr_err(clr_err),
    .locked(locked), .err(err), .err_sticky(err_sticky), .err_cnt(err_cnt),
    .rev_cnt(rev_cnt), .rev_pulse(rev_pulse), .phase(phase), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic [3:0] q, input logic [3:0] qb, input logic e, input logic c);
    q_in = q;
    qb_in = qb;
    en = e;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask
  task automatic smp(input logic [3:0] q);
    tick(q, ~q, 1'b1, 1'b0);
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_sticky"}, 32'(err_sticky), 0);
    chk({tag, "_errcnt"}, 32'(err_cnt), 0);
    chk({tag, "_revcnt"}, 32'(rev_cnt), 0);
    chk({tag, "_revpulse"}, 32'(rev_pulse), 0);
    chk({tag, "_phase"}, 32'(phase), 0);
    chk({tag, "_state"}, 32'(state), 0);
  endtask
  initial begin
    #2 rst = 1'b1;
    #1 all_zero("rst_async");
    tick(4'd0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(4'd0, 4'd0, 1'b0, 1'b0);
    all_zero("rst_release");
    smp(4'b0001);
    smp(4'b0010);
    chk("s1_state", 32'(state), 1);
    chk("s1_phase", 32'(phase), 0);
    smp(4'b0100);
    chk("s2_phase", 32'(phase), 1);
    smp(4'b1000);
    chk("s3_phase", 32'(phase), 2);
    smp(4'b0001);
    chk("s4_phase", 32'(phase), 3);
    chk("s4_locked", 32'(locked), 0);
    smp(4'b0010);
    chk("s5_locked", 32'(locked), 1);
    chk("s5_state", 32'(state), 2);
    chk("s5_revpulse", 32'(rev_pulse), 0);
    chk("s5_revcnt", 32'(rev_cnt), 0);
    smp(4'b0100);
    smp(4'b1000);
    smp(4'b0001);
    chk("s8_revpulse", 32'(rev_pulse), 0);
    smp(4'b0010);
    chk("s9_revpulse", 32'(rev_pulse), 1);
    chk("s9_revcnt", 32'(rev_cnt), 1);
    chk("s9_phase", 32'(phase), 0);
    smp(4'b0110);
    chk("s10_revpulse", 32'(rev_pulse), 0);
    chk("s10_phase", 32'(phase), 1);
    smp(4'b0100);
    chk("mh_err", 32'(err), 1);
    chk("mh_sticky", 32'(err_sticky), 1);
    chk("mh_errcnt", 32'(err_cnt), 1);
    chk("mh_locked", 32'(locked), 0);
    chk("mh_state", 32'(state), 3);
    chk("mh_phase", 32'(phase), 1);
    smp(4'b1000);
    chk("mh_err_once", 32'(err), 0);
    chk("mh_search", 32'(state), 1);
    smp(4'b0001);
    smp(4'b0010);
    smp(4'b0100);
    chk("relock_not_yet", 32'(locked), 0);
    smp(4'b1000);
    chk("relock", 32'(locked), 1);
    chk("relock_revcnt", 32'(rev_cnt), 1);
    smp(4'b0001);
    tick(4'b0100, 4'b1111, 1'b1, 1'b0);
    chk("rev2_pulse", 32'(rev_pulse), 1);
    chk("rev2_cnt", 32'(rev_cnt), 2);
    smp(4'b0010);
    chk("qb_err", 32'(err), 1);
    chk("qb_errcnt", 32'(err_cnt), 2);
    chk("qb_state", 32'(state), 3);
    chk("qb_phase", 32'(phase), 0);
    smp(4'b0100);
    smp(4'b1000);
    smp(4'b0001);
    smp(4'b0010);
    smp(4'b0100);
    chk("relock2", 32'(locked), 1);
    chk("relock2_revcnt", 32'(rev_cnt), 2);
    smp(4'b1000);
    smp(4'b0001);
    smp(4'b0100);
    chk("rev3_cnt", 32'(rev_cnt), 3);
    smp(4'b1000);
    chk("skip_err", 32'(err), 1);
    chk("skip_errcnt", 32'(err_cnt), 3);
    chk("skip_locked", 32'(locked), 0);
    chk("skip_phase", 32'(phase), 2);
    smp(4'b0001);
    smp(4'b0010);
    smp(4'b0100);
    smp(4'b1000);
    smp(4'b0001);
    chk("relock3", 32'(locked), 1);
    tick(4'b1111, 4'b1111, 1'b0, 1'b0);
    chk("rev4_cnt", 32'(rev_cnt), 4);
    tick(4'b1111, 4'b1111, 1'b0, 1'b0);
    chk("gate_revpulse", 32'(rev_pulse), 0);
    chk("gate_err", 32'(err), 0);
    tick(4'b1111, 4'b1111, 1'b0, 1'b0);
    smp(4'b0010);
    chk("gate_locked", 32'(locked), 1);
    chk("gate_revcnt", 32'(rev_cnt), 4);
    smp(4'b0100);
    chk("gate_resume_locked", 32'(locked), 1);
    chk("gate_resume_phase", 32'(phase), 1);
    chk("gate_errcnt", 32'(err_cnt), 3);
    for (int k = 0; k < 300; k++) begin
      tick(4'b0000, 4'b1111, 1'b1, 1'b0);
      smp(4'b0001);
      smp(4'b0010);
      smp(4'b0100);
      smp(4'b1000);
      smp(4'b0001);
    end
    tick(4'd0, 4'd0, 1'b0, 1'b0);
    chk("sat_errcnt", 32'(err_cnt), 255);
    chk("sat_sticky", 32'(err_sticky), 1);
    chk("sat_locked", 32'(locked), 1);
    tick(4'd0, 4'd0, 1'b0, 1'b1);
    chk("clr_errcnt", 32'(err_cnt), 0);
    chk("clr_sticky", 32'(err_sticky), 0);
    chk("clr_locked", 32'(locked), 1);
    tick(4'b0000, 4'b1111, 1'b1, 1'b0);
    tick(4'd0, 4'd0, 1'b0, 1'b1);
    chk("clrfault_errcnt", 32'(err_cnt), 1);
    chk("clrfault_sticky", 32'(err_sticky), 1);
    chk("clrfault_err", 32'(err), 1);
    chk("clrfault_state", 32'(state), 3);
    smp(4'b0001);
    smp(4'b0010);
    smp(4'b0100);
    smp(4'b1000);
    smp(4'b0001);
    tick(4'd0, 4'd0, 1'b0, 1'b0);
    chk("prerst_locked", 32'(locked), 1);
    #2 rst = 1'b1;
    #1 all_zero("rst_locked");
    tick(4'b0001, 4'b1110, 1'b1, 1'b0);
    rst = 1'b0;
    tick(4'd0, 4'd0, 1'b0, 1'b0);
    all_zero("rst_hold");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
- Sits directly downstream of the ring counter and consumes its one-hot output `q` and complement `qb`.
- Checks every enabled sample for a legal one-hot code and for the correct single-step rotation from the previous sample.
- Acquires lock after a run of clean steps, then counts full revolutions and errors.
- Drives status flags for LEDs, the bench and downstream sequencing logic.

Parameters:
- WIDTH, 4, number of ring stages (≥2).
- DIR, 0, expected rotation: 0 = bit i moves to bit i+1 (next = {q[W-2:0],q[W-1]}); 1 = bit i moves to bit i-1.
- LOCK_CNT, 4, consecutive correct transitions required to assert locked (1..15).

Ports:
- clk, in, 1, system clock; all state updates on its rising edge.
- rst, in, 1, asynchronous, active-high reset.
- en, in, 1, sample qualifier; inputs are ignored when 0.
- q_in, in, WIDTH, ring counter output.
- qb_in, in, WIDTH, ring counter complement output.
- clr_err, in, 1, synchronous clear of err_sticky and err_cnt.
- locked, out, 1, 1 while the ring is verified rotating correctly.
- err, out, 1, one-cycle pulse per detected fault while locked.
- err_sticky, out, 1, set by any err, held until clr_err or rst.
- err_cnt, out, 8, saturating error count.
- rev_cnt, out, 16, completed revolutions while locked; wraps.
- rev_pulse, out, 1, one-cycle pulse when the phase wraps to 0 while locked.
- phase, out, clog2(WIDTH), index of the set bit of the last valid sample.
- state, out, 2, FSM state for debug: 0 IDLE, 1 SEARCH, 2 LOCKED, 3 FAULT.

Behaviour:
- Reset:
  - rst=1 asynchronously forces all outputs, counters, internal sample registers and good_cnt to 0; state = IDLE.
  - Deassertion takes effect at the next clk edge.
- Pipeline:
  - Stage 1 registers q_in, qb_in and en at edge N.
  - Stage 2 evaluates the sample at edge N+1, when all outputs reflecting that sample update.
  - Latency is 2 edges; throughput is 1 sample per clock.
- Valid sample: exactly one bit of q set AND qb == ~q. All-zero or multi-hot codes are invalid.
- Correct transition: current sample is valid AND equals the previous valid sample rotated one step in direction DIR.
- Previous sample: updated only by valid enabled samples.
- en=0: the sample is not taken; FSM, counters and previous sample hold; err and rev_pulse stay 0.
- FSM (advances on enabled samples only):
  - IDLE: valid sample → SEARCH, good_cnt=0. Invalid sample → stay.
  - SEARCH:
    - Correct transition → good_cnt+1; on reaching LOCK_CNT → LOCKED, good_cnt=0.
    - Valid but wrong step → good_cnt=0, stay.
    - Invalid → IDLE.
    - Errors are not counted.
  - LOCKED:
    - Correct transition → stay.
    - Anything else → FAULT, err=1 for one cycle, err_sticky=1, err_cnt+1 saturating at 255.
  - FAULT: valid sample → SEARCH, good_cnt=0. Invalid → stay. No further err pulses.
- locked = 1 exactly while state == LOCKED.
- phase: updated on every valid enabled sample in any state.
- Revolution:
  - In LOCKED, a correct transition landing on phase 0 gives rev_pulse=1 for one cycle and rev_cnt+1, mod 2^16.
  - The transition that enters LOCKED does not count.
- clr_err:
  - Clears err_sticky and err_cnt at that edge.
  - If an error is detected on the same edge, the error wins: err_sticky=1, err_cnt=1.
- Reset mid-operation: immediate return to IDLE, counts lost; relock requires a fresh valid sample plus LOCK_CNT correct transitions.
- Widths:
  - err_cnt never wraps.
  - rev_cnt wraps 0xFFFF→0x0000 without a flag.
  - good_cnt is 4 bits.

Test Plan (WIDTH=4, DIR=0, LOCK_CNT=4):
1. Reset check: assert rst mid-clock with no clk edge → all outputs 0 immediately, state=0.
2. Clean rotation:
   - Stimulus: en=1, q = 0001,0010,0100,1000,0001,... with qb=~q.
   - Required: locked=1 two edges after the 5th sample; phase tracks 0,1,2,3; the first rev_pulse occurs on the return to 0001 while locked; rev_cnt=1 then increments every 4 samples.
3. Fault injection:
   - Stimulus: while locked, inject q=0110.
   - Required: err one-cycle pulse, err_sticky=1, err_cnt=1, locked=0, state=FAULT.
   - Then resume 0100,1000,0001,0010,0100 → relock after 4 correct steps.
4. Complement/skip faults while locked:
   - q=0100 with qb=1111 → err, err_cnt increments.
   - A legal skip 0001→0100 → err, err_cnt increments.
5. Enable gating: insert 3 cycles of en=0 carrying garbage (q=1111) between good samples → no err, locked stays 1, rev_cnt unaffected.
6. Saturation and clear:
   - Force 300 faults (alternate lock/fault) → err_cnt=255.
   - clr_err alone → err_cnt=0, err_sticky=0.
   - clr_err on the same edge as a fault → err_cnt=1, err_sticky=1.
   - Assert rst while locked → all outputs 0, IDLE.
